// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: command ops, register modes, FSM states.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_SHR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_ROR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ASR  = 3'b101,
        OP_CLR  = 3'b110,
        OP_NOP  = 3'b111
    } op_t;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shift_seq_fill_mux.sv
// Serial fill bits for the controlled register, derived from the latched op and
// the register's current contents; forced to 0 outside shift cycles.
module shift_seq_fill_mux
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_t              op,
    input  logic             en,
    input  logic [WIDTH-1:0] q,
    output logic             sil,
    output logic             sir
);

    always_comb begin
        sil = 1'b0;
        sir = 1'b0;
        if (en) begin
            case (op)
                OP_ROR:  sil = q[0];
                OP_ASR:  sil = q[WIDTH-1];
                OP_ROL:  sir = q[WIDTH-1];
                default: begin
                    sil = 1'b0;
                    sir = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for a 4-mode universal shift register.
// Optional SHIFT_SEQ_ABORT_EN adds an abort input and aborted flag on done.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] sr_q,
    output logic [1:0]       sr_s,
    output logic [WIDTH-1:0] sr_i,
    output logic             sr_sil,
    output logic             sr_sir,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             busy,
    output logic             done
);

    state_t           state, state_nx;
    op_t              op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] count_q;
    logic             accept;

    assign cmd_ready = (state == IDLE) && clear_n;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

`ifdef SHIFT_SEQ_ABORT_EN
    logic aborted_q;
    logic abort_hit;
    assign abort_hit = abort && ((state == LOAD) || (state == SHIFT));
    assign aborted   = done && aborted_q;
`endif

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state   <= IDLE;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            count_q <= '0;
`ifdef SHIFT_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q    <= op_t'(cmd_op);
                data_q  <= cmd_data;
                count_q <= cmd_count;
            end else if (state == SHIFT) begin
                count_q <= count_q - 1'b1;
            end
`ifdef SHIFT_SEQ_ABORT_EN
            if (accept)         aborted_q <= 1'b0;
            else if (abort_hit) aborted_q <= 1'b1;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        sr_s     = MODE_HOLD;
        sr_i     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op_t'(cmd_op))
                        OP_LOAD, OP_CLR: state_nx = LOAD;
                        OP_NOP:          state_nx = DONE;
                        default:         state_nx = (cmd_count == '0) ? DONE : SHIFT;
                    endcase
                end
            end
            LOAD: begin
                sr_s     = MODE_LOAD;
                sr_i     = (op_q == OP_CLR) ? '0 : data_q;
                state_nx = DONE;
            end
            SHIFT: begin
                sr_s = ((op_q == OP_SHL) || (op_q == OP_ROL)) ? MODE_SHL : MODE_SHR;
                if (count_q == CNT_W'(1)) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
`ifdef SHIFT_SEQ_ABORT_EN
        if (abort_hit) state_nx = DONE;
`endif
    end

    shift_seq_fill_mux #(.WIDTH(WIDTH)) u_fill (
        .op  (op_q),
        .en  (state == SHIFT),
        .q   (sr_q),
        .sil (sr_sil),
        .sir (sr_sir)
    );

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: shift_sequencer driving a behavioural 4-bit universal shift register.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [3:0] cmd_data = 4'b0000;
    logic [2:0] cmd_count = 3'b000;
    logic [3:0] a = 4'b0000;
    logic [1:0] sr_s;
    logic [3:0] sr_i;
    logic       sr_sil, sr_sir, busy, done;
`ifdef SHIFT_SEQ_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // universal shift register: 00 load, 01 right (SIL->MSB), 10 left (SIR->LSB), 11 hold
    always @(posedge clk) begin
        case (sr_s)
            2'b00: a <= sr_i;
            2'b01: a <= {sr_sil, a[3:1]};
            2'b10: a <= {a[2:0], sr_sir};
            default: a <= a;
        endcase
    end

    shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk), .clear_n(clear_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .sr_q(a),
        .sr_s(sr_s), .sr_i(sr_i), .sr_sil(sr_sil), .sr_sir(sr_sir),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for cmd_ready, presents one command, returns in cycle T+1.
    task automatic issue(input logic [2:0] op, input logic [3:0] data, input logic [2:0] cnt);
        int n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        checks++;
        if (!cmd_ready) begin failures++; $display("FAIL issue_ready_timeout got=%b exp=1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] data);
        issue(3'b000, data, 3'd0);
        tick(); tick();
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        tick(); tick();
        checks++; if (sr_s !== 2'b11) begin failures++; $display("FAIL reset_sr_s got=%b exp=11", sr_s); end
        checks++; if ({cmd_ready, busy, done, sr_sil, sr_sir} !== 5'b0) begin failures++;
            $display("FAIL reset_flags got=%b exp=00000", {cmd_ready, busy, done, sr_sil, sr_sir}); end
        checks++; if (sr_i !== 4'b0000) begin failures++; $display("FAIL reset_sr_i got=%b exp=0000", sr_i); end
        clear_n = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_load();
        issue(3'b000, 4'b1011, 3'd0);
        checks++; if ({sr_s, sr_i, busy, cmd_ready} !== 8'b00_1011_1_0) begin failures++;
            $display("FAIL load_cycle got=%b exp=00101110", {sr_s, sr_i, busy, cmd_ready}); end
        tick();
        checks++; if ({done, sr_s, a} !== 7'b1_11_1011) begin failures++;
            $display("FAIL load_done got=%b exp=1111011", {done, sr_s, a}); end
        tick();
        checks++; if ({cmd_ready, done} !== 2'b10) begin failures++;
            $display("FAIL load_ready_t3 got=%b exp=10", {cmd_ready, done}); end
    endtask

    task automatic test_ror();
        issue(3'b011, 4'b0000, 3'd1);
        checks++; if ({sr_s, sr_sil} !== 3'b01_1) begin failures++; $display("FAIL ror_shift got=%b exp=011", {sr_s, sr_sil}); end
        tick();
        checks++; if ({done, a} !== 5'b1_1101) begin failures++; $display("FAIL ror_done got=%b exp=11101", {done, a}); end
        tick();
    endtask

    task automatic test_shl();
        do_load(4'b1011);
        issue(3'b010, 4'b0000, 3'd2);
        checks++; if ({sr_s, sr_sir, done} !== 4'b10_0_0) begin failures++; $display("FAIL shl_c1 got=%b exp=1000", {sr_s, sr_sir, done}); end
        tick();
        checks++; if ({sr_s, a} !== 6'b10_0110) begin failures++; $display("FAIL shl_c2 got=%b exp=100110", {sr_s, a}); end
        tick();
        checks++; if ({done, sr_s, a} !== 7'b1_11_1100) begin failures++; $display("FAIL shl_done got=%b exp=1111100", {done, sr_s, a}); end
        tick();
    endtask

    task automatic test_asr_and_zero_count();
        do_load(4'b1000);
        issue(3'b101, 4'b0000, 3'd3);
        checks++; if ({sr_s, sr_sil} !== 3'b01_1) begin failures++; $display("FAIL asr_c1 got=%b exp=011", {sr_s, sr_sil}); end
        tick();
        checks++; if (a !== 4'b1100) begin failures++; $display("FAIL asr_a1 got=%b exp=1100", a); end
        tick();
        checks++; if (a !== 4'b1110) begin failures++; $display("FAIL asr_a2 got=%b exp=1110", a); end
        tick();
        checks++; if ({done, a} !== 5'b1_1111) begin failures++; $display("FAIL asr_done got=%b exp=11111", {done, a}); end
        tick();
        issue(3'b001, 4'b0000, 3'd0);
        checks++; if ({done, sr_s} !== 3'b1_11) begin failures++; $display("FAIL shr0_done got=%b exp=111", {done, sr_s}); end
        tick();
        checks++; if ({a, sr_s, busy} !== 7'b1111_11_0) begin failures++; $display("FAIL shr0_after got=%b exp=1111110", {a, sr_s, busy}); end
    endtask

    task automatic test_clear_mid_command();
        do_load(4'b1011);
        issue(3'b100, 4'b0000, 3'd7);
        checks++; if ({sr_s, sr_sir} !== 3'b10_1) begin failures++; $display("FAIL rol_c1 got=%b exp=101", {sr_s, sr_sir}); end
        tick();
        checks++; if (a !== 4'b0111) begin failures++; $display("FAIL rol_a1 got=%b exp=0111", a); end
        tick();
        clear_n = 1'b0;
        checks++; if ({a, busy} !== 5'b1110_1) begin failures++; $display("FAIL rol_c3 got=%b exp=11101", {a, busy}); end
        tick();
        checks++; if ({busy, done, cmd_ready, sr_s} !== 5'b0_0_0_11) begin failures++;
            $display("FAIL clr_mid_state got=%b exp=00011", {busy, done, cmd_ready, sr_s}); end
        checks++; if (a !== 4'b1101) begin failures++; $display("FAIL clr_mid_a got=%b exp=1101", a); end
        clear_n = 1'b1;
        tick();
        checks++; if ({done, cmd_ready, a} !== 6'b0_1_1101) begin failures++;
            $display("FAIL clr_mid_after got=%b exp=011101", {done, cmd_ready, a}); end
    endtask

    task automatic test_busy_ignore_then_clr();
        issue(3'b001, 4'b0000, 3'd3);
        cmd_valid = 1'b1; cmd_op = 3'b110; cmd_data = 4'b1111; cmd_count = 3'd0;
        checks++; if ({cmd_ready, sr_s} !== 3'b0_01) begin failures++; $display("FAIL ign_c1 got=%b exp=001", {cmd_ready, sr_s}); end
        tick();
        checks++; if ({sr_s, a} !== 6'b01_0110) begin failures++; $display("FAIL ign_c2 got=%b exp=010110", {sr_s, a}); end
        tick();
        checks++; if ({sr_s, a} !== 6'b01_0011) begin failures++; $display("FAIL ign_c3 got=%b exp=010011", {sr_s, a}); end
        tick();
        checks++; if ({done, cmd_ready, a} !== 6'b1_0_0001) begin failures++; $display("FAIL ign_done got=%b exp=100001", {done, cmd_ready, a}); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ign_idle_ready got=%b exp=1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        checks++; if ({sr_s, sr_i} !== 6'b00_0000) begin failures++; $display("FAIL clr_cycle got=%b exp=000000", {sr_s, sr_i}); end
        tick();
        checks++; if ({done, a} !== 5'b1_0000) begin failures++; $display("FAIL clr_done got=%b exp=10000", {done, a}); end
        tick();
    endtask

`ifdef SHIFT_SEQ_ABORT_EN
    task automatic test_abort();
        do_load(4'b1011);
        issue(3'b010, 4'b0000, 3'd5);
        tick();
        abort = 1'b1;
        checks++; if ({sr_s, a} !== 6'b10_0110) begin failures++; $display("FAIL abort_c2 got=%b exp=100110", {sr_s, a}); end
        tick();
        abort = 1'b0;
        checks++; if ({done, aborted, sr_s, a} !== 8'b1_1_11_1100) begin failures++;
            $display("FAIL abort_done got=%b exp=11111100", {done, aborted, sr_s, a}); end
        tick();
        checks++; if ({aborted, busy, a} !== 6'b0_0_1100) begin failures++; $display("FAIL abort_after got=%b exp=001100", {aborted, busy, a}); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_ror();
        test_shl();
        test_asr_and_zero_count();
        test_clear_mid_command();
        test_busy_ignore_then_clr();
`ifdef SHIFT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
